// File: rtl/rotn_pkg.sv
// Shared command codes, config/status bit positions and alphabet sizes
// for the ROT-N cipher FIFO.
package rotn_pkg;

    typedef enum logic [1:0] {
        CTL_LOAD_LO = 2'b00,
        CTL_LOAD_HI = 2'b01,
        CTL_COMMIT  = 2'b10,
        CTL_POP     = 2'b11
    } ctl_e;

    localparam int CFG_DECRYPT = 7;
    localparam int CFG_FLUSH   = 6;
    localparam int CFG_DIGIT   = 5;

    localparam int ST_ERR   = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_EMPTY = 5;

    localparam int ALPHA_LEN = 26;
    localparam int DIGIT_LEN = 10;

    // Config writes carry a 5-bit shift; values 26..31 fold back into range.
    function automatic logic [4:0] reduce_shift(input logic [4:0] raw);
        return (raw >= 5'(ALPHA_LEN)) ? raw - 5'(ALPHA_LEN) : raw;
    endfunction

endpackage

// File: rtl/rotn_cipher_fifo_if.sv
// Pin-limited host bus of the cipher tile: 2-bit command, 4-bit nibble in,
// 8-bit data/status out.
interface rotn_cipher_fifo_if;
    logic [1:0] ctl;
    logic [3:0] data_in;
    logic [7:0] data_out;

    modport master (output ctl, output data_in, input  data_out);
    modport slave  (input  ctl, input  data_in, output data_out);
endinterface

// File: rtl/rotn_char_map.sv
// Combinational ROT-N character map: letters rotate within their case,
// digits optionally rotate within 0..9, everything else passes through.
module rotn_char_map
    import rotn_pkg::*;
(
    input  logic [7:0] char_in,
    input  logic [4:0] shift,
    input  logic       decrypt,
    input  logic       digit_mode,
    output logic [7:0] char_out
);

    localparam logic [7:0] UPPER_A = 8'h41;
    localparam logic [7:0] UPPER_Z = 8'h5A;
    localparam logic [7:0] LOWER_A = 8'h61;
    localparam logic [7:0] LOWER_Z = 8'h7A;
    localparam logic [7:0] DIGIT_0 = 8'h30;
    localparam logic [7:0] DIGIT_9 = 8'h39;

    logic [3:0] shift_mod10;
    logic [4:0] alpha_s;
    logic [3:0] digit_s;
    logic [7:0] base;
    logic [7:0] sum;
    logic       is_alpha;
    logic       is_digit;

    // Decrypt digits by the inverse of (shift mod 10), not of the letter shift.
    always_comb begin
        shift_mod10 = 4'(shift % 5'd10);
        alpha_s     = shift;
        digit_s     = shift_mod10;
        if (decrypt) begin
            alpha_s = (shift == 5'd0) ? 5'd0 : 5'(ALPHA_LEN) - shift;
            digit_s = (shift_mod10 == 4'd0) ? 4'd0 : 4'(DIGIT_LEN) - shift_mod10;
        end

        is_alpha = 1'b0;
        is_digit = 1'b0;
        base     = UPPER_A;
        if (char_in >= UPPER_A && char_in <= UPPER_Z) begin
            is_alpha = 1'b1;
        end else if (char_in >= LOWER_A && char_in <= LOWER_Z) begin
            is_alpha = 1'b1;
            base     = LOWER_A;
        end else if (digit_mode && char_in >= DIGIT_0 && char_in <= DIGIT_9) begin
            is_digit = 1'b1;
            base     = DIGIT_0;
        end

        sum = (char_in - base) + (is_alpha ? {3'b000, alpha_s} : {4'b0000, digit_s});
        if (is_alpha && sum >= 8'(ALPHA_LEN))
            sum = sum - 8'(ALPHA_LEN);
        if (is_digit && sum >= 8'(DIGIT_LEN))
            sum = sum - 8'(DIGIT_LEN);

        char_out = (is_alpha || is_digit) ? base + sum : char_in;
    end

endmodule

// File: rtl/rotn_cipher_fifo.sv
// ROT-N cipher tile: nibble staging, config register, edge-qualified
// COMMIT/POP, DEPTH-entry output FIFO and data/status output mux.
module rotn_cipher_fifo
    import rotn_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int DEFAULT_SHIFT = 13
) (
    input  logic               clk,
    input  logic               reset,
    rotn_cipher_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [3:0]       stage_lo, stage_hi;
    logic [4:0]       shift;
    logic             decrypt, digit_mode;
    logic [1:0]       prev_ctl;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       count;
    logic             err;
    logic [7:0]       char_reg;
    logic             show_char;

    logic [7:0] cmd_byte;
    logic [7:0] mapped;
    logic       commit_fire, pop_fire, full, empty, do_push, do_pop;
    logic [7:0] status;

    assign cmd_byte    = {stage_hi, stage_lo};
    assign commit_fire = (ctl_e'(bus.ctl) == CTL_COMMIT) && (bus.ctl != prev_ctl);
    assign pop_fire    = (ctl_e'(bus.ctl) == CTL_POP)    && (bus.ctl != prev_ctl);
    assign full        = (count == 4'(DEPTH));
    assign empty       = (count == 4'd0);
    assign do_push     = commit_fire && !bus.data_in[0] && !full;
    assign do_pop      = pop_fire && !empty;

    rotn_char_map u_char_map (
        .char_in    (cmd_byte),
        .shift      (shift),
        .decrypt    (decrypt),
        .digit_mode (digit_mode),
        .char_out   (mapped)
    );

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= mapped;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_lo   <= 4'd0;
            stage_hi   <= 4'd0;
            shift      <= 5'(DEFAULT_SHIFT);
            decrypt    <= 1'b0;
            digit_mode <= 1'b0;
            prev_ctl   <= 2'b00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= 4'd0;
            err        <= 1'b0;
            char_reg   <= 8'h00;
            show_char  <= 1'b0;
        end else begin
            prev_ctl  <= bus.ctl;
            show_char <= pop_fire || (show_char && ctl_e'(bus.ctl) == CTL_POP);

            if (ctl_e'(bus.ctl) == CTL_LOAD_LO)
                stage_lo <= bus.data_in;
            if (ctl_e'(bus.ctl) == CTL_LOAD_HI)
                stage_hi <= bus.data_in;

            if (commit_fire && bus.data_in[0]) begin
                decrypt    <= cmd_byte[CFG_DECRYPT];
                digit_mode <= cmd_byte[CFG_DIGIT];
                shift      <= reduce_shift(cmd_byte[4:0]);
                if (cmd_byte[CFG_FLUSH]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= 4'd0;
                    err    <= 1'b0;
                end
            end

            // Overflowing push and underflowing pop both latch the sticky error.
            if (commit_fire && !bus.data_in[0] && full)
                err <= 1'b1;
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                count  <= count + 4'd1;
            end

            if (pop_fire) begin
                if (empty) begin
                    char_reg <= 8'h00;
                    err      <= 1'b1;
                end else begin
                    char_reg <= mem[rd_ptr];
                end
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                count  <= count - 4'd1;
            end
        end
    end

    always_comb begin
        status           = 8'h00;
        status[ST_ERR]   = err;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[3:0]      = count;
    end

    assign bus.data_out = show_char ? char_reg : status;

endmodule

// File: tb/tb_rotn_cipher_fifo.sv
// Self-checking bench for rotn_cipher_fifo: directed scenarios plus a random
// command stream, all compared against a queue-based behavioural model.
module tb_rotn_cipher_fifo;

    localparam int DEPTH         = 8;
    localparam int DEFAULT_SHIFT = 13;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    rotn_cipher_fifo_if bus ();

    rotn_cipher_fifo #(.DEPTH(DEPTH), .DEFAULT_SHIFT(DEFAULT_SHIFT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_q[$];
    logic [3:0] m_slo, m_shi;
    int         m_shift;
    bit         m_dec, m_dig, m_err, m_show;
    logic [7:0] m_char;
    logic [1:0] m_prev;

    function automatic logic [7:0] ref_cipher(input logic [7:0] c, input int sh,
                                              input bit dec, input bit dig);
        int ci, s, ds;
        ci = int'(c);
        s  = dec ? (26 - sh) % 26 : sh;
        ds = dec ? (10 - sh % 10) % 10 : sh % 10;
        if (ci >= 65 && ci <= 90)  return 8'(65 + (ci - 65 + s) % 26);
        if (ci >= 97 && ci <= 122) return 8'(97 + (ci - 97 + s) % 26);
        if (dig && ci >= 48 && ci <= 57) return 8'(48 + (ci - 48 + ds) % 10);
        return c;
    endfunction

    function automatic logic [7:0] model_out();
        int n;
        n = m_q.size();
        if (m_show) return m_char;
        return {m_err, n == DEPTH, n == 0, 1'b0, 4'(n)};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_slo = 0; m_shi = 0; m_shift = DEFAULT_SHIFT;
        m_dec = 0; m_dig = 0; m_err = 0; m_show = 0;
        m_char = 8'h00; m_prev = 2'b00;
    endfunction

    // Drive one command for one cycle and advance the model by its rules.
    task automatic drive(input logic [1:0] c, input logic [3:0] d);
        bit fire;
        logic [7:0] b;
        bus.ctl = c;
        bus.data_in = d;
        fire = (c != m_prev);
        b = {m_shi, m_slo};
        case (c)
            2'b00: m_slo = d;
            2'b01: m_shi = d;
            2'b10: if (fire) begin
                if (d[0]) begin
                    m_dec = b[7];
                    m_dig = b[5];
                    m_shift = int'(b[4:0]) % 26;
                    if (b[6]) begin
                        m_q.delete();
                        m_err = 0;
                    end
                end else if (m_q.size() == DEPTH) begin
                    m_err = 1;
                end else begin
                    m_q.push_back(ref_cipher(b, m_shift, m_dec, m_dig));
                end
            end
            default: if (fire) begin
                if (m_q.size() > 0) m_char = m_q.pop_front();
                else begin
                    m_char = 8'h00;
                    m_err = 1;
                end
            end
        endcase
        m_show = (c == 2'b11) ? (fire ? 1'b1 : m_show) : 1'b0;
        m_prev = c;
        @(negedge clk);
    endtask

    task automatic load_byte(input logic [7:0] b);
        drive(2'b00, b[3:0]);
        drive(2'b01, b[7:4]);
    endtask

    task automatic push_char(input logic [7:0] b);
        load_byte(b);
        drive(2'b10, 4'h0);
    endtask

    task automatic write_config(input logic [7:0] b);
        load_byte(b);
        drive(2'b10, 4'h1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.ctl = 2'b00;
        bus.data_in = 4'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        drive(2'b00, 4'h0);
        checks++;
        if (bus.data_out !== 8'h20) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h want 20", bus.data_out);
        end
    endtask

    task automatic test_default_rot13();
        push_char(8'h41);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h4E) begin
            errors++;
            $display("[TB] FAIL rot13_A: got %h want 4E", bus.data_out);
        end
        drive(2'b00, 4'h0);
    endtask

    task automatic test_decrypt_wrap();
        write_config(8'h83);
        push_char(8'h64);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h61) begin
            errors++;
            $display("[TB] FAIL decrypt_d: got %h want 61", bus.data_out);
        end
        write_config(8'h01);
        push_char(8'h7A);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h61) begin
            errors++;
            $display("[TB] FAIL wrap_z: got %h want 61", bus.data_out);
        end
        drive(2'b00, 4'h0);
    endtask

    task automatic test_digits();
        write_config(8'h25);
        push_char(8'h37);
        push_char(8'h21);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h32) begin
            errors++;
            $display("[TB] FAIL digit_7: got %h want 32", bus.data_out);
        end
        drive(2'b00, 4'h0);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h21) begin
            errors++;
            $display("[TB] FAIL passthru_bang: got %h want 21", bus.data_out);
        end
        drive(2'b00, 4'h0);
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        write_config(8'h40 | 8'(DEFAULT_SHIFT));
        for (int i = 0; i < DEPTH + 1; i++)
            push_char(8'($urandom_range(0, 255)));
        checks++;
        if (bus.data_out !== {1'b1, 1'b1, 1'b0, 1'b0, 4'(DEPTH)}) begin
            errors++;
            $display("[TB] FAIL overflow_status: got %h want %h", bus.data_out,
                     {1'b1, 1'b1, 1'b0, 1'b0, 4'(DEPTH)});
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = m_q[0];
            drive(2'b11, 4'h0);
            checks++;
            if (bus.data_out !== exp) begin
                errors++;
                $display("[TB] FAIL drain_order[%0d]: got %h want %h", i, bus.data_out, exp);
            end
            drive(2'b00, 4'h0);
        end
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL underflow_char: got %h want 00", bus.data_out);
        end
        drive(2'b00, 4'h0);
        checks++;
        if (bus.data_out !== 8'hA0) begin
            errors++;
            $display("[TB] FAIL underflow_status: got %h want A0", bus.data_out);
        end
    endtask

    task automatic test_held_pop();
        logic [7:0] exp;
        write_config(8'h40);
        for (int i = 0; i < 3; i++)
            push_char(8'($urandom_range(8'h41, 8'h5A)));
        exp = m_q[0];
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 4'h0);
            checks++;
            if (bus.data_out !== exp) begin
                errors++;
                $display("[TB] FAIL held_pop[%0d]: got %h want %h", i, bus.data_out, exp);
            end
        end
        drive(2'b00, 4'h0);
        checks++;
        if (bus.data_out !== 8'h02) begin
            errors++;
            $display("[TB] FAIL held_pop_count: got %h want 02", bus.data_out);
        end
        write_config(8'h40);
        checks++;
        if (bus.data_out !== 8'h20) begin
            errors++;
            $display("[TB] FAIL flush_status: got %h want 20", bus.data_out);
        end
    endtask

    task automatic test_shift_reduce_and_reset();
        write_config(8'h1F);
        push_char(8'h41);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h46) begin
            errors++;
            $display("[TB] FAIL shift31_A: got %h want 46", bus.data_out);
        end
        push_char(8'h42);
        push_char(8'h43);
        apply_reset();
        drive(2'b00, 4'h0);
        checks++;
        if (bus.data_out !== 8'h20) begin
            errors++;
            $display("[TB] FAIL midqueue_reset: got %h want 20", bus.data_out);
        end
        push_char(8'h41);
        drive(2'b11, 4'h0);
        checks++;
        if (bus.data_out !== 8'h4E) begin
            errors++;
            $display("[TB] FAIL post_reset_A: got %h want 4E", bus.data_out);
        end
        drive(2'b00, 4'h0);
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic [3:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 400; i++) begin
            c = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            if (c == 2'b10 && $urandom_range(0, 3) != 0)
                d[0] = 1'b0;
            if (c == 2'b10 && d[0] && $urandom_range(0, 1) == 0)
                m_shi = m_shi;
            drive(c, d);
            exp = model_out();
            checks++;
            if (bus.data_out !== exp) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %h want %h", i, bus.data_out, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ctl = 2'b00;
        bus.data_in = 4'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_default_rot13();
        test_decrypt_wrap();
        test_digits();
        test_overflow();
        test_held_pop();
        test_shift_reduce_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
